audio_dac_tx: RTL and testbench

//  Serial transmitter that drives a Pmod DA2-style 12-bit DAC (DAC121S101 SPI-like frame).
//  It is the output-direction counterpart of the microphone capture path.

---
 rtl/audio_dac_pkg.sv | 19 +
 rtl/audio_dac_fifo.sv | 52 +++++
 rtl/audio_dac_tx.sv | 133 +++++++++++++
 tb/tb_audio_dac_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_dac_pkg.sv
// Shared constants and FSM encoding for the Pmod DA2-style DAC transmitter.
package audio_dac_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int PD_W    = 2;

  localparam logic [PD_W-1:0] PD_NORMAL = 2'b00;
  localparam logic [PD_W-1:0] PD_1K     = 2'b01;
  localparam logic [PD_W-1:0] PD_100K   = 2'b10;
  localparam logic [PD_W-1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/audio_dac_fifo.sv
// Small synchronous FIFO with count-based full/empty and show-ahead read data.
module audio_dac_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/audio_dac_tx.sv
// Serialises 12-bit samples into 16-bit SYNC/SCLK/DIN frames for a DAC121S101.
// Optional input buffering is enabled by defining AUDIO_DAC_FIFO_EN.
module audio_dac_tx
  import audio_dac_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SYNC_GAP   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [PD_W-1:0]   pd_mode,
  output logic              dac_sync,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(2*CLK_DIV);
  localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_W - 1);

  if (CLK_DIV < 2 || FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("audio_dac_tx: CLK_DIV must be >= 2 and FIFO_DEPTH a power of two");
  end

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 load;
  logic [FRAME_W-1:0]   load_word;
  logic                 div_end;
  logic                 last_bit;

`ifdef AUDIO_DAC_FIFO_EN
  logic                   fifo_full, fifo_empty;
  logic [PD_W+DATA_W-1:0] fifo_head;

  audio_dac_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PD_W + DATA_W)
  ) u_fifo (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .push_i  (sample_valid && !fifo_full),
    .wdata_i ({pd_mode, sample_in}),
    .pop_i   (load),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sample_ready = !fifo_full;
  assign load         = (state_q == ST_IDLE) && !fifo_empty;
  assign load_word    = {2'b00, fifo_head};
`else
  assign sample_ready = (state_q == ST_IDLE);
  assign load         = sample_valid && sample_ready;
  assign load_word    = {2'b00, pd_mode, sample_in};
`endif

  assign div_end  = (div_q == DIV_LAST);
  assign last_bit = (bit_q == BIT_LAST);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (div_end && last_bit) state_d = (SYNC_GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Divider, bit counter and shifter advance only while shifting; everything else parks at zero.
  always_comb begin
    div_d   = '0;
    bit_d   = '0;
    gap_d   = '0;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (load) shift_d = load_word;
      end
      ST_SHIFT: begin
        bit_d = bit_q;
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
        end
      end
      ST_GAP: begin
        gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
      end
      default: shift_d = '0;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    dac_sync   = (state_q != ST_SHIFT);
    dac_sclk   = (state_q != ST_SHIFT) || (div_q < DIV_HALF);
    dac_din    = (state_q == ST_SHIFT) && shift_q[FRAME_W-1];
    frame_done = (state_q == ST_GAP) && (gap_q == '0);
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: scoreboard of expected frame words checked by a wire monitor.
module tb_audio_dac_tx;
  import audio_dac_pkg::*;

`ifdef AUDIO_DAC_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        CLK = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [1:0]  pd_mode = '0;
  logic        sample_ready, dac_sync, dac_sclk, dac_din, busy, frame_done;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  always #5 CLK = ~CLK;

  audio_dac_tx #(.CLK_DIV(4), .SYNC_GAP(2), .FIFO_DEPTH(4)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pd_mode      (pd_mode),
    .dac_sync     (dac_sync),
    .dac_sclk     (dac_sclk),
    .dac_din      (dac_din),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cyc();
    return int'($time / 10);
  endfunction

  // Wire monitor, sampled on the falling CLK edge.
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
  logic        in_frame = 1'b0;
  logic        b2b_expect = 1'b0;
  logic [15:0] cap = '0;
  int low_len = 0, falls = 0, hi_run = 0, frames = 0;
  int fall_cyc = 0, done_cyc = 0;
  int stray = 0, stray_done = 0, glitch = 0, rdy_busy = 0;

  always @(negedge CLK) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      prev_sync = 1'b1;
      prev_sclk = 1'b1;
      prev_din  = 1'b0;
      hi_run    = 0;
    end else begin
      if (frame_done !== (dac_sync && !prev_sync && in_frame)) stray_done++;
      if (dac_sync && (dac_sclk !== 1'b1 || dac_din !== 1'b0)) stray++;
`ifndef AUDIO_DAC_FIFO_EN
      if (busy && sample_ready) rdy_busy++;
`endif
      if (!dac_sync) begin
        if (prev_sync) begin
          if (b2b_expect) chk("sync_high_gap", hi_run, 3);
          in_frame = 1'b1;
          low_len  = 0;
          falls    = 0;
          cap      = '0;
          fall_cyc = cyc();
        end
        low_len++;
        if (prev_sclk && !dac_sclk) begin
          falls++;
          cap = {cap[14:0], dac_din};
        end
        if (!prev_sclk && !dac_sclk && dac_din !== prev_din) glitch++;
      end else begin
        if (!prev_sync && in_frame) begin
          chk("sync_low_len", low_len, 128);
          chk("fall_edges", falls, 16);
          chk("frame_done_pulse", frame_done, 1'b1);
          chk("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("frame_word", cap, exp_q.pop_front());
          done_cyc = cyc();
          frames++;
          in_frame = 1'b0;
          hi_run   = 0;
        end
        hi_run++;
      end
      prev_sync = dac_sync;
      prev_sclk = dac_sclk;
      prev_din  = dac_din;
    end
  end

  task automatic send(input logic [11:0] s, input logic [1:0] pd, output int t);
    int waited;
    waited = 0;
    @(negedge CLK);
    sample_in    = s;
    pd_mode      = pd;
    sample_valid = 1'b1;
    while (!sample_ready && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    chk("accept_timeout", sample_ready, 1'b1);
    t = cyc();
    if (sample_ready) exp_q.push_back({2'b00, pd, s});
    @(posedge CLK);
    #1;
    sample_valid = 1'b0;
    sample_in    = 12'($urandom);
    pd_mode      = 2'($urandom);
  endtask

  task automatic wait_frames(input int n, input string tag);
    for (int i = 0; i < 2000 && frames < n; i++) @(negedge CLK);
    chk(tag, frames >= n, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 rst_n = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3, idle_bad, fr0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sync", dac_sync, 1'b1);
    chk("rst_sclk", dac_sclk, 1'b1);
    chk("rst_din", dac_din, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_ready", sample_ready, 1'b1);
    @(negedge CLK);
    #2 rst_n = 1'b1;

    // Single frame with a mixed bit pattern
    send(12'hA5C, PD_NORMAL, t1);
    wait_frames(1, "t1_frame_timeout");
    chk("t1_sync_fall", fall_cyc, t1 + 1 + LAT);
    chk("t1_frame_done", done_cyc, t1 + 129 + LAT);

    // Power-down bits set, all-zero sample
    send(12'h000, PD_HIZ, t3);
    wait_frames(2, "t3_frame_timeout");
    chk("t3_sync_fall", fall_cyc, t3 + 1 + LAT);
    chk("t3_frame_done", done_cyc, t3 + 129 + LAT);

    // Back-to-back frames with valid held high
    send(12'h001, PD_NORMAL, t1);
    @(negedge CLK);
    #1 b2b_expect = 1'b1;
    send(12'hFFF, PD_NORMAL, t2);
`ifndef AUDIO_DAC_FIFO_EN
    chk("t2_second_accept", t2 - t1, 131);
`endif
    send(12'h123, PD_1K, t2);
    send(12'h456, PD_100K, t2);
    wait_frames(6, "t2_frames_timeout");
    b2b_expect = 1'b0;

    // Reset in the middle of bit 7
    send(12'h5A3, PD_NORMAL, t1);
    repeat (1 + LAT + 8*7 + 3) @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sync", dac_sync, 1'b1);
    chk("abort_sclk", dac_sclk, 1'b1);
    chk("abort_din", dac_din, 1'b0);
    chk("abort_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge CLK);
    #2 rst_n = 1'b1;
    chk("abort_no_frame", frames, 6);
    send(12'h5A3, PD_NORMAL, t1);
    wait_frames(7, "post_reset_frame_timeout");
    chk("post_reset_sync_fall", fall_cyc, t1 + 1 + LAT);

    // Long idle stretch
    fr0 = frames;
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (dac_sync !== 1'b1 || dac_sclk !== 1'b1 || dac_din !== 1'b0 || frame_done !== 1'b0) idle_bad++;
    end
    chk("idle_lines", idle_bad, 0);
    chk("idle_no_frames", frames, fr0);

`ifdef AUDIO_DAC_FIFO_EN
    begin
      int acc;
      logic rdy5;
      do_reset();
      fr0 = frames;
      acc = 0;
      rdy5 = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        @(negedge CLK);
        sample_in    = 12'(i);
        pd_mode      = PD_NORMAL;
        sample_valid = 1'b1;
        if (i == 6) rdy5 = sample_ready;
        if (sample_ready) begin
          exp_q.push_back({4'b0000, 12'(i)});
          acc++;
        end
      end
      @(posedge CLK);
      #1 sample_valid = 1'b0;
      chk("fifo_accepted", acc, 5);
      chk("fifo_ready_c5", rdy5, 1'b0);
      for (int i = 0; i < 300 && in_frame == 1'b0; i++) @(negedge CLK);
      @(negedge CLK);
      #1 b2b_expect = 1'b1;
      wait_frames(fr0 + 5, "fifo_frames_timeout");
      b2b_expect = 1'b0;
    end
`endif

    repeat (5) @(negedge CLK);
    chk("stray_frame_done", stray_done, 0);
    chk("idle_line_levels", stray, 0);
    chk("din_change_sclk_low", glitch, 0);
`ifndef AUDIO_DAC_FIFO_EN
    chk("ready_while_busy", rdy_busy, 0);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
